srsw_stream_ctrl: RTL and testbench
===================================

SRSW_STREAM_CTRL -- requirements
Module: srsw_stream_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of data path and memory.
REQ-002 SHALL have parameter ADDR_WIDTH, default 2, memory address width (depth = 2**ADDR_WIDTH = 4).
REQ-003 SHALL have port clk, input, 1, single clock for all state.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, upstream word offered.
REQ-006 SHALL have port in_ready, output, 1, block accepts word this cycle.
REQ-007 SHALL have port in_data, input, DATA_WIDTH, upstream word.
REQ-008 SHALL have port out_valid, output, 1, out_data holds a word.
REQ-009 SHALL have port out_ready, input, 1, downstream consumes word this cycle.
REQ-010 SHALL have port out_data, output, DATA_WIDTH, head word.
REQ-011 SHALL have port mem_wen, output, 1, memory write enable.
REQ-012 SHALL have port mem_waddr, output, ADDR_WIDTH, memory write address.
REQ-013 SHALL have port mem_wdata, output, DATA_WIDTH, memory write data.
REQ-014 SHALL have port mem_ren, output, 1, memory read enable (registers mem_raddr in memory).
REQ-015 SHALL have port mem_raddr, output, ADDR_WIDTH, memory read address.
REQ-016 SHALL have port mem_rdata, input, DATA_WIDTH, memory read data, valid the cycle after mem_ren, held while mem_ren low.
REQ-017 SHALL have port count, output, ADDR_WIDTH+1 (3), total words held (memory + output buffer), max 6.

Function
REQ-018 SHALL operate as an in-order stream FIFO: 4-slot external single-read single-write memory plus 2-entry internal output buffer.
REQ-019 SHALL track wptr, rptr (ADDR_WIDTH bits, wrap 3->0), mem_cnt (0..4), rd_pending flag, buf_cnt (0..2).
REQ-020 SHALL drive in_ready = (mem_cnt != 4), from registered state only; no combinational path from out_ready or in_valid.
REQ-021 SHALL drive mem_wen = in_valid && in_ready, mem_waddr = wptr, mem_wdata = in_data; wptr increments on each accepted push.
REQ-022 SHALL treat a slot as unread when written and not yet read-issued; unread = mem_cnt - rd_pending.
REQ-023 SHALL assert mem_ren = (unread != 0) && (buf_cnt + rd_pending - pop < 2), pop = out_valid && out_ready; mem_raddr = rptr; rptr increments on each mem_ren.
REQ-024 SHALL set rd_pending on next edge equal to mem_ren; in a cycle with rd_pending high, SHALL capture mem_rdata into the output buffer tail at the edge.
REQ-025 SHALL decrement mem_cnt only on the capture edge (slot stays reserved while its read is in flight); simultaneous push and capture leaves mem_cnt unchanged.
REQ-026 SHALL present buffer head on out_data with out_valid = (buf_cnt != 0); simultaneous pop and capture with buf_cnt=2 not possible per REQ-023; with buf_cnt=1 SHALL shift then append.
REQ-027 SHALL give latency: word accepted at edge E -> mem_ren in cycle after E (if first) -> out_valid from edge E+2.
REQ-028 SHALL sustain one push and one pop per cycle in steady streaming.
REQ-029 SHALL drive count = mem_cnt + buf_cnt; out_data value while out_valid low is don't-care.
REQ-030 SHALL never write a slot whose read is pending or unread (guaranteed by REQ-020/REQ-025).

Reset
REQ-031 SHALL, while rst high, immediately force wptr=rptr=0, mem_cnt=0, rd_pending=0, buf_cnt=0, out_valid=0, count=0, mem_ren=0.
REQ-032 SHALL hold in_ready and mem_wen low while rst high; in_ready=1 from first cycle after deassertion.
REQ-033 SHALL discard all stored and in-flight words on reset; out_data register contents not reset-dependent.

Verification
REQ-034 Single word: after reset push 0xA5A50001 -> mem_wen=1 waddr=0 same cycle; mem_ren=1 raddr=0 next cycle; out_valid=1 out_data=0xA5A50001 two edges after accept.
REQ-035 Fill: out_ready=0, in_valid=1 words 1..8 -> exactly 6 accepted (1..6), in_ready=0, count=6; then out_ready=1 -> out_data 1..6 in order, count returns 0.
REQ-036 Streaming: in_valid=out_ready=1 for 20 words -> one out word per cycle after 2-cycle fill, order preserved, count stable at 2-3.
REQ-037 Wrap: push/pop 9 words singly -> mem_waddr and mem_raddr sequences 0,1,2,3,0,1,2,3,0; data intact.
REQ-038 Reset mid-operation: 3 words held, rst asserted mid-cycle -> out_valid, mem_ren, count drop to 0 before next edge; post-reset push 0x0000BEEF is first and only word out.
REQ-039 Random: 2000 cycles random in_valid/out_ready/in_data with behavioural memory model -> out stream matches queue reference, count never exceeds 6.

Source files
------------

// File: rtl/srsw_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : srsw_stream_ctrl
//  Description : In-order stream FIFO.  Words are stored in an external
//                single-read / single-write memory of 2**ADDR_WIDTH slots and
//                pre-fetched into a 2-entry internal output buffer so that a
//                registered-read memory can still sustain one push and one
//                pop per cycle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   clock for all state
//    rst        in   asynchronous active-high reset
//    in_valid   in   upstream word offered
//    in_ready   out  word accepted this cycle (registered state only)
//    in_data    in   upstream word
//    out_valid  out  out_data holds the head word
//    out_ready  in   downstream consumes the head word this cycle
//    out_data   out  head word
//    mem_wen    out  memory write enable
//    mem_waddr  out  memory write address
//    mem_wdata  out  memory write data
//    mem_ren    out  memory read enable (memory registers mem_raddr)
//    mem_raddr  out  memory read address
//    mem_rdata  in   memory read data, valid the cycle after mem_ren
//    count      out  words held (memory + output buffer)
// ============================================================================
module srsw_stream_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  mem_wen,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_ren,
   output logic [ADDR_WIDTH-1:0] mem_raddr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [ADDR_WIDTH:0]   count
);

   localparam int CNT_W   = ADDR_WIDTH + 1;
   localparam int c_DEPTH = 2 ** ADDR_WIDTH;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0]      mem_cnt_q, mem_cnt_d;
   logic                  rd_pending_q, rd_pending_d;
   logic [1:0]            buf_cnt_q, buf_cnt_d;
   logic [DATA_WIDTH-1:0] buf0_q, buf0_d;   // buffer head
   logic [DATA_WIDTH-1:0] buf1_q, buf1_d;   // buffer second entry

   // ------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------
   logic             w_push;
   logic             w_pop;
   logic             w_ren;
   logic [CNT_W-1:0] w_unread;
   logic [2:0]       w_occ;
   logic [1:0]       w_tail;

   // in_ready depends only on registered state (and reset), never on
   // out_ready or in_valid.  A slot stays counted in mem_cnt until its read
   // data is captured, so a full memory can never have a pending slot
   // overwritten.
   assign in_ready = ~rst & (mem_cnt_q != CNT_W'(c_DEPTH));
   assign w_push   = in_valid & in_ready;
   assign w_pop    = out_valid & out_ready;

   // Slots written but not yet read-issued.
   assign w_unread = mem_cnt_q - CNT_W'(rd_pending_q);

   // Buffer occupancy as seen after this edge, including the read already
   // in flight.  A read is only issued when its data is guaranteed a free
   // buffer entry at capture time.
   assign w_occ = {1'b0, buf_cnt_q} + {2'b00, rd_pending_q} - {2'b00, w_pop};
   assign w_ren = (w_unread != '0) && (w_occ < 3'd2);

   // Entry index where captured read data lands, after any pop shift.
   assign w_tail = buf_cnt_q - {1'b0, w_pop};

   always_comb begin
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      mem_cnt_d    = mem_cnt_q;
      rd_pending_d = w_ren;
      buf_cnt_d    = buf_cnt_q;
      buf0_d       = buf0_q;
      buf1_d       = buf1_q;

      if (w_push) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (w_ren) begin
         rptr_d = rptr_q + 1'b1;
      end

      // Memory slot released only when its data is captured.
      mem_cnt_d = mem_cnt_q + CNT_W'(w_push) - CNT_W'(rd_pending_q);

      // Pop shifts first, then captured data is appended at the tail.
      if (w_pop) begin
         buf0_d = buf1_q;
      end
      if (rd_pending_q) begin
         if (w_tail == 2'd0) begin
            buf0_d = mem_rdata;
         end else begin
            buf1_d = mem_rdata;
         end
      end
      buf_cnt_d = buf_cnt_q - {1'b0, w_pop} + {1'b0, rd_pending_q};
   end

   // ------------------------------------------------------------------
   // Control registers (asynchronous reset)
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         mem_cnt_q    <= '0;
         rd_pending_q <= 1'b0;
         buf_cnt_q    <= '0;
      end else begin
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         mem_cnt_q    <= mem_cnt_d;
         rd_pending_q <= rd_pending_d;
         buf_cnt_q    <= buf_cnt_d;
      end
   end

   // Buffer data needs no reset: out_valid qualifies it.
   always_ff @(posedge clk) begin
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign out_valid = (buf_cnt_q != 2'd0);
   assign out_data  = buf0_q;
   assign mem_wen   = w_push;
   assign mem_waddr = wptr_q;
   assign mem_wdata = in_data;
   assign mem_ren   = w_ren;
   assign mem_raddr = rptr_q;
   assign count     = mem_cnt_q + CNT_W'(buf_cnt_q);

endmodule
`default_nettype wire

// File: tb/tb_srsw_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_srsw_stream_ctrl
//  Description : Self-checking bench for srsw_stream_ctrl with a behavioural
//                registered-read memory and a queue scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_srsw_stream_ctrl;

   localparam int DW = 32;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          mem_wen;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ren;
   logic [AW-1:0] mem_raddr;
   logic [DW-1:0] mem_rdata;
   logic [AW:0]   count;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] mem_model [4];

   always #5 clk = ~clk;

   srsw_stream_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .mem_wen   (mem_wen),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .mem_ren   (mem_ren),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata),
      .count     (count)
   );

   // Behavioural memory: registered read, output held while mem_ren low.
   always @(posedge clk) begin
      if (mem_wen) mem_model[mem_waddr] <= mem_wdata;
      if (mem_ren) mem_rdata <= mem_model[mem_raddr];
   end

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         tests_run++;
         if (int'(count) != exp_q.size()) begin
            tests_failed++;
            $display("FAIL count_track: count=%0d expected=%0d", count, exp_q.size());
         end
         if (out_valid && out_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL sb_underflow: got out_data=%h with nothing expected", out_data);
            end else begin
               logic [DW-1:0] e;
               e = exp_q.pop_front();
               if (out_data !== e) begin
                  tests_failed++;
                  $display("FAIL sb_data: out_data=%h expected=%h", out_data, e);
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
            tests_run++;
            if (mem_wen !== 1'b1 || mem_wdata !== in_data) begin
               tests_failed++;
               $display("FAIL mem_write: wen=%b wdata=%h expected wen=1 wdata=%h",
                        mem_wen, mem_wdata, in_data);
            end
         end
      end
   end

   task automatic drain(input int max_cycles);
      int n;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (count != '0 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (count != '0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL drain: count=%0d out_valid=%b expected 0 0", count, out_valid);
      end
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      in_data  = 32'h1234_5678;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || count !== '0 || mem_ren !== 1'b0 ||
          in_ready !== 1'b0 || mem_wen !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state: ov=%b cnt=%0d ren=%b ir=%b wen=%b expected all 0",
                  out_valid, count, mem_ren, in_ready, mem_wen);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_release: in_ready=%b expected 1", in_ready);
      end
   endtask

   task automatic test_single();
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_data   = 32'hA5A5_0001;
      out_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (mem_wen !== 1'b1 || mem_waddr !== 2'd0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_write: wen=%b waddr=%0d ov=%b expected 1 0 0",
                  mem_wen, mem_waddr, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (mem_ren !== 1'b1 || mem_raddr !== 2'd0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_read: ren=%b raddr=%0d ov=%b expected 1 0 0",
                  mem_ren, mem_raddr, out_valid);
      end
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_early: out_valid=%b expected 0", out_valid);
      end
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001) begin
         tests_failed++;
         $display("FAIL single_out: ov=%b data=%h expected 1 a5a50001", out_valid, out_data);
      end
      drain(10);
   endtask

   task automatic test_fill();
      int word;
      int accepted;
      word = 1;
      accepted = 0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int c = 0; c < 20; c++) begin
         in_valid = (word <= 8);
         in_data  = word;
         @(negedge clk);
         if (in_valid && in_ready) begin
            accepted++;
            word++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (accepted != 6 || in_ready !== 1'b0 || count != 3'd6) begin
         tests_failed++;
         $display("FAIL fill: accepted=%0d in_ready=%b count=%0d expected 6 0 6",
                  accepted, in_ready, count);
      end
      drain(20);
   endtask

   task automatic test_back_to_back();
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         in_valid  = 1'b1;
         out_ready = 1'b1;
         in_data   = 32'hC000_0000 + i;
         @(negedge clk);
         if (i >= 3) begin
            tests_run++;
            if (out_valid !== 1'b1 || count < 3'd2 || count > 3'd3 || in_ready !== 1'b1) begin
               tests_failed++;
               $display("FAIL stream cycle %0d: ov=%b count=%0d ir=%b expected 1 2..3 1",
                        i, out_valid, count, in_ready);
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      drain(20);
   endtask

   task automatic test_wrap();
      int n;
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h5A00_0000 + i;
         @(negedge clk);
         tests_run++;
         if (mem_wen !== 1'b1 || mem_waddr !== 2'(i % 4)) begin
            tests_failed++;
            $display("FAIL wrap_waddr %0d: wen=%b waddr=%0d expected 1 %0d",
                     i, mem_wen, mem_waddr, i % 4);
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         n = 0;
         @(negedge clk);
         while (mem_ren !== 1'b1 && n < 5) begin
            @(negedge clk);
            n++;
         end
         tests_run++;
         if (mem_ren !== 1'b1 || mem_raddr !== 2'(i % 4)) begin
            tests_failed++;
            $display("FAIL wrap_raddr %0d: ren=%b raddr=%0d expected 1 %0d",
                     i, mem_ren, mem_raddr, i % 4);
         end
         n = 0;
         while (count != '0 && n < 8) begin
            @(negedge clk);
            n++;
         end
         @(posedge clk); #1;
      end
      drain(10);
   endtask

   task automatic test_reset_mid();
      int pops;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 32'hDEAD_0000 + i;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      in_valid = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || mem_ren !== 1'b0 || count !== '0 ||
          in_ready !== 1'b0 || mem_wen !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid: ov=%b ren=%b cnt=%0d ir=%b wen=%b expected all 0",
                  out_valid, mem_ren, count, in_ready, mem_wen);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h0000_BEEF;
      out_ready = 1'b1;
      pops = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            pops++;
            tests_run++;
            if (out_data !== 32'h0000_BEEF) begin
               tests_failed++;
               $display("FAIL reset_mid_data: out_data=%h expected 0000beef", out_data);
            end
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      tests_run++;
      if (pops != 1) begin
         tests_failed++;
         $display("FAIL reset_mid_pops: pops=%0d expected 1", pops);
      end
   endtask

   task automatic test_random();
      @(posedge clk); #1;
      for (int c = 0; c < 2000; c++) begin
         in_valid  = ($urandom_range(0, 99) < 60);
         out_ready = ($urandom_range(0, 99) < 55);
         in_data   = $urandom;
         @(negedge clk);
         tests_run++;
         if (count > 3'd6) begin
            tests_failed++;
            $display("FAIL random_count: count=%0d exceeds 6", count);
         end
         @(posedge clk); #1;
      end
      drain(30);
   endtask

   initial begin
      fork
         begin
            #2_000_000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
         end
      join_none
      test_reset();
      test_single();
      test_fill();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      test_random();
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL leftover: %0d words never delivered", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
